alarm_clock_multi: RTL
======================

ALARM_CLOCK_MULTI -- requirements
Module: alarm_clock_multi

Interface
REQ-001 SHALL have parameter N_ALARMS, default 2, number of independent alarms (1..8).
REQ-002 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minutes (1..59).
REQ-003 SHALL have parameter RING_SEC, default 60, ring auto-timeout in seconds (1..255).
REQ-004 SHALL have port Clk, in, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port Reset, in, 1, synchronous, active-high.
REQ-006 SHALL have port Pulse, in, 1, one-second strobe, one Clk cycle wide.
REQ-007 SHALL have ports Timeset, Alarmset, Minadv, Hrsadv, Snooze, Dismiss, in, 1 each, level controls.
REQ-008 SHALL have port Alarmsel, in, max(1,clog2(N_ALARMS)), alarm being set or displayed.
REQ-009 SHALL have port Alarmon, in, N_ALARMS, per-alarm enable.
REQ-010 SHALL have ports H1, H0, M1, M0, S1, S0, out, 4 each, BCD display digits.
REQ-011 SHALL have port Buzz, out, 1, high while any alarm is in RING.
REQ-012 SHALL have port Active_alarm, out, N_ALARMS, bit k high while alarm k is in RING.

Function
REQ-013 Time SHALL be hours 0-23, minutes 0-59, seconds 0-59; each alarm holds hours 0-23 and minutes 0-59.
REQ-014 Pulse with Timeset=0 SHALL advance seconds; 59->0 carries to minutes; 59->0 carries to hours; 23:59:59->00:00:00.
REQ-015 Timeset=1 SHALL freeze seconds; each Pulse with Minadv=1 SHALL add 1 minute (59->0, no hour carry); each Pulse with Hrsadv=1 SHALL add 1 hour (23->0); both high advances both.
REQ-016 Alarmset=1 with Timeset=0 SHALL apply Minadv/Hrsadv per Pulse, with the same wrap rules, to alarm[Alarmsel] while time keeps running; Timeset SHALL take priority over Alarmset.
REQ-017 Alarmsel >= N_ALARMS SHALL be ignored: no alarm modified; display shows 00:00:00.
REQ-018 Display SHALL show alarm[Alarmsel] with S1=S0=0 while Alarmset=1 and Timeset=0, else current time; outputs registered, updated the cycle after the Pulse.
REQ-019 A match SHALL occur only when a counting Pulse makes seconds 0 and H:M equals alarm k with Alarmon[k]=1; Timeset adjustments SHALL never match.
REQ-020 Each alarm SHALL have an FSM with states IDLE, RING, SNOOZED.
REQ-021 IDLE->RING on match; RING->RING on re-match restarts the timeout; SNOOZED->RING on match.
REQ-022 RING->SNOOZED on Snooze=1, loading a countdown of SNOOZE_MIN*60 seconds.
REQ-023 RING->IDLE on Dismiss=1, on Alarmon[k]=0, or after RING_SEC Pulses in RING.
REQ-024 SNOOZED decrements once per Pulse; ->RING the Pulse it reaches 0; ->IDLE on Dismiss=1 or Alarmon[k]=0.
REQ-025 Snooze and Dismiss SHALL act on all alarms concurrently; Dismiss SHALL win over Snooze; disable SHALL win over match.
REQ-026 Buzz and Active_alarm SHALL rise the cycle after the matching Pulse and fall the cycle after the causing event.

Reset
REQ-027 Reset SHALL override all inputs, including Pulse.
REQ-028 Reset SHALL set time 00:00:00, all alarms 00:00, all FSMs IDLE, countdowns 0, and Buzz=0, Active_alarm=0, all digits 0, the cycle after assertion.
REQ-029 Reset asserted during RING or SNOOZED SHALL return to IDLE with no further buzz.

Verification
REQ-030 Reset, Alarmon=0, 3661 Pulses -> 01:01:01, Buzz=0.
REQ-031 Timeset=1 with Hrsadv for 23 Pulses and Minadv for 59 Pulses, Timeset=0, 59 Pulses -> 23:59:59; next Pulse -> 00:00:00, no carry into alarms.
REQ-032 Alarm0=00:02, Alarmon=01, 120 Pulses from reset -> Buzz=1 and Active_alarm=01 the cycle after Pulse 120; 60 more Pulses (RING_SEC=60) -> Buzz=0.
REQ-033 SNOOZE_MIN=1: ring, Snooze for one cycle -> Buzz=0; 60 Pulses later Buzz=1.
REQ-034 Snooze and Dismiss asserted in the same cycle during RING -> IDLE, Buzz stays 0 through 120 further Pulses.
REQ-035 Two alarms set to the same minute -> Active_alarm=11; Alarmon=01 mid-ring -> Active_alarm=01 next cycle; Reset -> 00:00:00, Buzz=0.

Source files
------------

// File: rtl/alarm_clock_multi.sv
// Multi-alarm 24-hour clock with per-alarm ring/snooze FSMs and BCD display.
// Ports:
//   Clk, Reset (sync, active-high), Pulse (1 Hz strobe, one Clk wide)
//   Timeset/Alarmset/Minadv/Hrsadv   : time and alarm adjustment controls
//   Snooze/Dismiss                   : act on every alarm at once
//   Alarmsel                         : alarm shown/edited while Alarmset=1
//   Alarmon                          : per-alarm enable
//   H1 H0 M1 M0 S1 S0                : registered BCD display digits
//   Buzz, Active_alarm               : registered ring indicators
module alarm_clock_multi #(
    parameter int unsigned N_ALARMS   = 2,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Pulse,
    input  logic                Timeset,
    input  logic                Alarmset,
    input  logic                Minadv,
    input  logic                Hrsadv,
    input  logic                Snooze,
    input  logic                Dismiss,
    input  logic [((N_ALARMS > 1) ? $clog2(N_ALARMS) : 1)-1:0] Alarmsel,
    input  logic [N_ALARMS-1:0] Alarmon,
    output logic [3:0]          H1,
    output logic [3:0]          H0,
    output logic [3:0]          M1,
    output logic [3:0]          M0,
    output logic [3:0]          S1,
    output logic [3:0]          S0,
    output logic                Buzz,
    output logic [N_ALARMS-1:0] Active_alarm
);

    localparam int unsigned SEL_W  = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int unsigned RING_W = 8;
    localparam int unsigned SNZ_W  = 12;
    localparam logic [SNZ_W-1:0]  SNZ_LOAD = SNZ_W'(SNOOZE_MIN * 60);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZED} alarm_state_e;

    logic [4:0] hrs_q, hrs_d;
    logic [5:0] min_q, min_d, sec_q, sec_d;
    logic       rollover;

    logic [4:0]        ahr_q  [N_ALARMS];
    logic [4:0]        ahr_d  [N_ALARMS];
    logic [5:0]        amin_q [N_ALARMS];
    logic [5:0]        amin_d [N_ALARMS];
    alarm_state_e      st_q   [N_ALARMS];
    alarm_state_e      st_d   [N_ALARMS];
    logic [RING_W-1:0] ring_q [N_ALARMS];
    logic [RING_W-1:0] ring_d [N_ALARMS];
    logic [SNZ_W-1:0]  snz_q  [N_ALARMS];
    logic [SNZ_W-1:0]  snz_d  [N_ALARMS];
    logic [N_ALARMS-1:0] match;
    logic [N_ALARMS-1:0] active_d;

    logic [4:0] dh;
    logic [5:0] dm, ds;

    // Timekeeping: count when Timeset=0, else manual minute/hour advance.
    always_comb begin
        hrs_d    = hrs_q;
        min_d    = min_q;
        sec_d    = sec_q;
        rollover = 1'b0;
        if (Pulse) begin
            if (Timeset) begin
                if (Minadv) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                if (Hrsadv) hrs_d = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
            end else if (sec_q == 6'd59) begin
                sec_d    = 6'd0;
                rollover = 1'b1;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    hrs_d = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    // Alarm editing; an out-of-range Alarmsel matches no k and edits nothing.
    always_comb begin
        for (int k = 0; k < int'(N_ALARMS); k++) begin
            ahr_d[k]  = ahr_q[k];
            amin_d[k] = amin_q[k];
            if (Pulse && Alarmset && !Timeset && (Alarmsel == SEL_W'(k))) begin
                if (Minadv) amin_d[k] = (amin_q[k] == 6'd59) ? 6'd0 : amin_q[k] + 6'd1;
                if (Hrsadv) ahr_d[k]  = (ahr_q[k] == 5'd23) ? 5'd0 : ahr_q[k] + 5'd1;
            end
        end
    end

    // Match uses the new time against the alarm setting held before this Pulse.
    always_comb begin
        match = '0;
        for (int k = 0; k < int'(N_ALARMS); k++) begin
            match[k] = rollover && Alarmon[k] && (hrs_d == ahr_q[k]) && (min_d == amin_q[k]);
        end
    end

    // Per-alarm FSM next state; priority: disable/Dismiss, Snooze, match, Pulse timers.
    always_comb begin
        active_d = '0;
        for (int k = 0; k < int'(N_ALARMS); k++) begin
            st_d[k]   = st_q[k];
            ring_d[k] = ring_q[k];
            snz_d[k]  = snz_q[k];
            if (!Alarmon[k] || Dismiss) begin
                st_d[k]   = IDLE;
                ring_d[k] = '0;
                snz_d[k]  = '0;
            end else if ((st_q[k] == RING) && Snooze) begin
                st_d[k]   = SNOOZED;
                ring_d[k] = '0;
                snz_d[k]  = SNZ_LOAD;
            end else if (match[k]) begin
                st_d[k]   = RING;
                ring_d[k] = '0;
                snz_d[k]  = '0;
            end else if (Pulse) begin
                case (st_q[k])
                    RING: begin
                        if (ring_q[k] == RING_LAST) begin
                            st_d[k]   = IDLE;
                            ring_d[k] = '0;
                        end else begin
                            ring_d[k] = ring_q[k] + RING_W'(1);
                        end
                    end
                    SNOOZED: begin
                        if (snz_q[k] <= SNZ_W'(1)) begin
                            st_d[k]   = RING;
                            ring_d[k] = '0;
                            snz_d[k]  = '0;
                        end else begin
                            snz_d[k] = snz_q[k] - SNZ_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
            active_d[k] = (st_d[k] == RING);
        end
    end

    // Display source: selected alarm while editing alarms, otherwise time.
    always_comb begin
        dh = '0;
        dm = '0;
        ds = '0;
        if (Alarmset && !Timeset) begin
            for (int k = 0; k < int'(N_ALARMS); k++) begin
                if (Alarmsel == SEL_W'(k)) begin
                    dh = ahr_d[k];
                    dm = amin_d[k];
                end
            end
        end else begin
            dh = hrs_d;
            dm = min_d;
            ds = sec_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hrs_q <= '0;
            min_q <= '0;
            sec_q <= '0;
            for (int k = 0; k < int'(N_ALARMS); k++) begin
                ahr_q[k]  <= '0;
                amin_q[k] <= '0;
                st_q[k]   <= IDLE;
                ring_q[k] <= '0;
                snz_q[k]  <= '0;
            end
            H1 <= '0; H0 <= '0; M1 <= '0; M0 <= '0; S1 <= '0; S0 <= '0;
            Buzz         <= 1'b0;
            Active_alarm <= '0;
        end else begin
            hrs_q <= hrs_d;
            min_q <= min_d;
            sec_q <= sec_d;
            for (int k = 0; k < int'(N_ALARMS); k++) begin
                ahr_q[k]  <= ahr_d[k];
                amin_q[k] <= amin_d[k];
                st_q[k]   <= st_d[k];
                ring_q[k] <= ring_d[k];
                snz_q[k]  <= snz_d[k];
            end
            H1 <= 4'(dh / 5'd10);
            H0 <= 4'(dh % 5'd10);
            M1 <= 4'(dm / 6'd10);
            M0 <= 4'(dm % 6'd10);
            S1 <= 4'(ds / 6'd10);
            S0 <= 4'(ds % 6'd10);
            Buzz         <= |active_d;
            Active_alarm <= active_d;
        end
    end

endmodule
